// File: rtl/hit_feeder.sv
// hit_feeder: upstream input stage for hxmpp.
// Buffers incoming hits in a small FIFO, drains them as single-cycle write
// strobes, tracks end-of-event and reports the per-event hit count.
module hit_feeder #(
  parameter int ROWINDEXBITS = 4,
  parameter int COLINDEXBITS = 4,
  parameter int HITINFOBITS  = 8,
  parameter int FIFODEPTH    = 16,
  parameter int HITCOUNTBITS = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  input  logic [ROWINDEXBITS-1:0]              in_row,
  input  logic [COLINDEXBITS-1:0]              in_col,
  input  logic [HITINFOBITS-1:0]               in_hitInfo,
  output logic                                 in_ready,
  input  logic                                 eventEnd,
  input  logic                                 hold,
  output logic                                 write,
  output logic [ROWINDEXBITS+COLINDEXBITS-1:0] writeSSID,
  output logic [HITINFOBITS-1:0]               writeHitInfo,
  output logic                                 drained,
  output logic [HITCOUNTBITS-1:0]              eventHits
);

  localparam int SSIDBITS  = ROWINDEXBITS + COLINDEXBITS;
  localparam int ENTRYBITS = SSIDBITS + HITINFOBITS;
  localparam int ADDRBITS  = $clog2(FIFODEPTH);
  localparam logic [ADDRBITS:0] FULLCOUNT = (ADDRBITS+1)'(FIFODEPTH);

  logic [ENTRYBITS-1:0]    mem [FIFODEPTH];
  logic [ADDRBITS-1:0]     wrPtr;
  logic [ADDRBITS-1:0]     rdPtr;
  logic [ADDRBITS:0]       count;
  logic [HITCOUNTBITS-1:0] hitCount;
  logic                    pending;

  logic                    push;
  logic                    pop;
  logic                    drainNow;
  logic [ENTRYBITS-1:0]    inEntry;
  logic [ENTRYBITS-1:0]    head;

  assign in_ready = (count != FULLCOUNT);
  assign push     = in_valid && in_ready;
  // Pop only sees entries already stored; a hit arriving this cycle waits an edge.
  assign pop      = (count != '0) && !hold;
  assign drainNow = pending && (count == '0) && !pop && !push;
  assign inEntry  = {in_row, in_col, in_hitInfo};
  assign head     = mem[rdPtr];

  // FIFO storage: write the incoming hit at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= inEntry;
    end
  end

  // Pointers, occupancy, output register, hit counting and event tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      count        <= '0;
      write        <= 1'b0;
      writeSSID    <= '0;
      writeHitInfo <= '0;
      drained      <= 1'b0;
      eventHits    <= '0;
      hitCount     <= '0;
      pending      <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + 1'b1;
      end

      write <= pop;
      if (pop) begin
        rdPtr        <= rdPtr + 1'b1;
        writeSSID    <= head[ENTRYBITS-1 -: SSIDBITS];
        writeHitInfo <= head[HITINFOBITS-1:0];
        if (hitCount != '1) begin
          hitCount <= hitCount + 1'b1;
        end
      end

      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      // Completion wins over a repeated eventEnd at the same edge.
      drained <= drainNow;
      if (drainNow) begin
        eventHits <= hitCount;
        hitCount  <= '0;
        pending   <= 1'b0;
      end else if (eventEnd) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
